div_seq_ctrl: RTL
=================

DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits (min 4).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-004 SHALL have port start  input  1  request; sampled only while idle.
REQ-005 SHALL have port sgn  input  1  1 = two's-complement operands, 0 = unsigned; captured with start.
REQ-006 SHALL have port dividend  input  WIDTH  numerator; captured with start.
REQ-007 SHALL have port divisor  input  WIDTH  denominator; captured with start.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse; q and r valid.
REQ-010 SHALL have port q  output  WIDTH  quotient, held until the next accepted start.
REQ-011 SHALL have port r  output  WIDTH  remainder, held until the next accepted start.
REQ-012 SHALL have port dz  output  1  divide-by-zero flag, valid with done.
REQ-013 SHALL have port ovf  output  1  signed overflow flag (most-negative / -1), valid with done.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, FIX; busy = (state != IDLE).
REQ-015 IDLE: start=1 at edge N captures operands; sgn=1 converts each operand to its magnitude and records the quotient and remainder signs; enters RUN with the iteration counter at 0.
REQ-016 RUN: one non-restoring iteration per clock on a (WIDTH+1)-bit partial remainder. The iteration shifts left one bit. It subtracts the divisor if the partial remainder is non-negative and adds it if negative. The new quotient bit is the inverted sign.
REQ-017 RUN SHALL last exactly WIDTH cycles (edges N+1..N+WIDTH), then enter FIX.
REQ-018 FIX: adds the divisor magnitude back if the final partial remainder is negative, applies the recorded signs, registers q/r/dz/ovf, pulses done, and returns to IDLE.
REQ-019 Latency: done=1 in the cycle after edge N+WIDTH+1; busy=1 in the cycles after edges N..N+WIDTH.
REQ-020 Signed results: quotient truncates toward zero; remainder takes the sign of the dividend; dividend = q*divisor + r always holds.
REQ-021 Signed most-negative/-1: q = most-negative value, r = 0, ovf = 1; ovf = 0 in every other case.
REQ-022 start while busy SHALL be ignored, with no effect on the operation in progress.
REQ-023 start in the same cycle as done (state IDLE) SHALL be accepted.
REQ-024 Inputs other than start SHALL be don't-care outside the capture cycle.

Reset
REQ-025 rst_n=0 at any edge, including mid-RUN or mid-FIX, SHALL force IDLE with busy=0, done=0, q=0, r=0, dz=0, ovf=0, and the counter at 0.
REQ-026 A start coincident with rst_n=0 SHALL be discarded.

Configuration
REQ-027 Macro DIV_ZERO_CHECK_EN defined: divisor=0 at capture skips RUN and goes directly to FIX. It gives q = all ones, r = dividend, dz = 1, ovf = 0, with done in the cycle after edge N+1.
REQ-028 Macro DIV_ZERO_CHECK_EN undefined: no zero detection; the full RUN sequence executes; q/r are whatever the algorithm yields; dz is tied to 0.

Structure
REQ-029 The shared package div_pkg SHALL hold the state enum (IDLE/RUN/FIX), the default WIDTH constant, and the counter width, $clog2(WIDTH+1).
REQ-030 The single-iteration add/subtract/shift SHALL be a combinational sub-module div_step (inputs: partial remainder, quotient shift register, divisor; outputs: next partial remainder, next quotient), instantiated once.

Verification (WIDTH=16)
REQ-031 Unsigned 100/7, start at edge N -> done after edge N+17; q=14, r=2, dz=0, ovf=0; busy high for 17 cycles.
REQ-032 Signed -100/7 -> q=0xFFF2, r=0xFFFE; signed 100/-7 -> q=0xFFF2, r=0x0002; unsigned 0xFFFF/0x0001 -> q=0xFFFF, r=0.
REQ-033 Signed 0x8000/0xFFFF -> q=0x8000, r=0, ovf=1; the same operands unsigned -> q=0, r=0x8000, ovf=0.
REQ-034 With DIV_ZERO_CHECK_EN, 1234/0 -> done after edge N+1, q=0xFFFF, r=1234, dz=1.
REQ-035 Start 50/5, re-assert start with 9/3 at edge N+5 -> that start is ignored and q=10, r=0 at N+17. Start 9/3 in the done cycle -> q=3, r=0 seventeen edges later.
REQ-036 rst_n=0 at edge N+8 of an operation -> the next cycle shows busy=0, done=0, q=0, r=0, and no done pulse follows; a subsequent 100/7 completes correctly.

Source files
------------

// File: rtl/div_pkg.sv
// Shared FSM state type, default width and counter sizing for the sequential divider.
package div_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    // Iteration counter width for a given operand width.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One non-restoring division iteration: shift {prem, quo} left, then add or subtract the divisor.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   prem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvsr,
    output logic [WIDTH:0]   prem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] dvsr_ext;

    always_comb begin
        shifted  = {prem[WIDTH-1:0], quo[WIDTH-1]};
        dvsr_ext = {1'b0, dvsr};
        prem_nxt = prem[WIDTH] ? shifted + dvsr_ext : shifted - dvsr_ext;
        quo_nxt  = {quo[WIDTH-2:0], ~prem_nxt[WIDTH]};
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequential signed/unsigned divider, one quotient bit per clock.
// Define DIV_ZERO_CHECK_EN to short-circuit divide-by-zero with dz reporting.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dz,
    output logic             ovf
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   prem_q, prem_nxt, prem_fix;
    logic [WIDTH-1:0] quo_q, quo_nxt, dvsr_q;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic             qneg_q, rneg_q, ovf_pend_q, dz_pend_q;
    logic             div_zero;
    logic             done_q, dz_q, ovf_q;
    logic [WIDTH-1:0] q_q, r_q;

`ifdef DIV_ZERO_CHECK_EN
    assign div_zero = (divisor == '0);
`else
    assign div_zero = 1'b0;
`endif

    assign dvd_mag  = (sgn && dividend[WIDTH-1]) ? -dividend : dividend;
    assign dvs_mag  = (sgn && divisor[WIDTH-1]) ? -divisor : divisor;
    assign prem_fix = prem_q[WIDTH] ? prem_q + {1'b0, dvsr_q} : prem_q;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .prem    (prem_q),
        .quo     (quo_q),
        .dvsr    (dvsr_q),
        .prem_nxt(prem_nxt),
        .quo_nxt (quo_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = div_zero ? FIX : RUN;
            RUN:     if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            prem_q     <= '0;
            quo_q      <= '0;
            dvsr_q     <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            ovf_pend_q <= 1'b0;
            dz_pend_q  <= 1'b0;
            done_q     <= 1'b0;
            dz_q       <= 1'b0;
            ovf_q      <= 1'b0;
            q_q        <= '0;
            r_q        <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: if (start) begin
                    cnt_q     <= '0;
                    dvsr_q    <= dvs_mag;
                    dz_pend_q <= div_zero;
                    if (div_zero) begin
                        // Preload so FIX yields q = all ones and r = raw dividend
                        prem_q     <= {1'b0, dividend};
                        quo_q      <= '1;
                        qneg_q     <= 1'b0;
                        rneg_q     <= 1'b0;
                        ovf_pend_q <= 1'b0;
                    end else begin
                        prem_q     <= '0;
                        quo_q      <= dvd_mag;
                        qneg_q     <= sgn & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        rneg_q     <= sgn & dividend[WIDTH-1];
                        ovf_pend_q <= sgn && (dividend == MOST_NEG) && (divisor == '1);
                    end
                end
                RUN: begin
                    prem_q <= prem_nxt;
                    quo_q  <= quo_nxt;
                    cnt_q  <= cnt_q + CW'(1);
                end
                FIX: begin
                    q_q    <= qneg_q ? -quo_q : quo_q;
                    r_q    <= rneg_q ? -prem_fix[WIDTH-1:0] : prem_fix[WIDTH-1:0];
                    dz_q   <= dz_pend_q;
                    ovf_q  <= ovf_pend_q;
                    done_q <= 1'b1;
                    cnt_q  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign done = done_q;
    assign q    = q_q;
    assign r    = r_q;
    assign dz   = dz_q;
    assign ovf  = ovf_q;

endmodule
